// File: rtl/io_panel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | io_panel_pkg : seven-segment patterns and digit-index encoding for io_panel |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
package io_panel_pkg;

  localparam int DIGIT_W = 2;

  localparam logic [DIGIT_W-1:0] D0 = 2'd0;
  localparam logic [DIGIT_W-1:0] D1 = 2'd1;
  localparam logic [DIGIT_W-1:0] D2 = 2'd2;
  localparam logic [DIGIT_W-1:0] D3 = 2'd3;

  // Active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [3:0] an_onehot_low(input logic [DIGIT_W-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_panel_hex_to_seg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hex_to_seg : combinational nibble to active-low seven-segment pattern      |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module hex_to_seg
  import io_panel_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/io_panel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | io_panel : debounced switch input and multiplexed hex display for the CPU  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module io_panel
  import io_panel_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int SCAN_DIV        = 50_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sw,
  input  logic [DATA_WIDTH-1:0] cpu_out,
  output logic [DATA_WIDTH-1:0] cpu_in,
  output logic [6:0]            seg,
  output logic [3:0]            an,
  output logic                  frame
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PRE_W-1:0] c_pre_max = PRE_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] c_deb_max = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] r_sync1, r_sync2, r_cand, r_disp;
  logic [DEB_W-1:0]      r_deb_cnt;
  logic [PRE_W-1:0]      r_presc;
  logic [DIGIT_W-1:0]    r_idx, w_idx_next;
  logic                  r_load_d;
  logic                  w_wrap, w_load;
  logic [3:0]            w_nibble, w_an;
  logic [6:0]            w_seg;

  // Whole-vector debounce: any change of the synchronized value restarts the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_cand    <= '0;
      r_deb_cnt <= '0;
      cpu_in    <= '0;
    end else begin
      r_sync1 <= sw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand    <= r_sync2;
        r_deb_cnt <= '0;
      end else if (r_deb_cnt != c_deb_max) begin
        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
      end else begin
        cpu_in <= r_cand;
      end
    end
  end

  assign w_wrap = (r_presc == c_pre_max);
  assign w_load = w_wrap && (r_idx == D3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + PRE_W'(1);
    end
  end

  // Digit ring: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= D0;
    end else begin
      r_idx <= w_idx_next;
    end
  end

  // Digit ring: next state
  always_comb begin
    w_idx_next = r_idx;
    if (w_wrap) begin
      case (r_idx)
        D0:      w_idx_next = D1;
        D1:      w_idx_next = D2;
        D2:      w_idx_next = D3;
        default: w_idx_next = D0;
      endcase
    end
  end

  // Digit ring: outputs
  always_comb begin
    w_nibble = r_disp[3:0];
    case (r_idx)
      D0:      w_nibble = r_disp[3:0];
      D1:      w_nibble = r_disp[7:4];
      D2:      w_nibble = r_disp[11:8];
      default: w_nibble = r_disp[15:12];
    endcase
    w_an = an_onehot_low(r_idx);
  end

  hex_to_seg u_hex_to_seg (
    .nibble  (w_nibble),
    .pattern (w_seg)
  );

  // The display value is only captured at the frame boundary so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp   <= '0;
      r_load_d <= 1'b0;
      frame    <= 1'b0;
      seg      <= SEG_BLANK;
      an       <= 4'hF;
    end else begin
      if (w_load) begin
        r_disp <= cpu_out;
      end
      r_load_d <= w_load;
      frame    <= r_load_d;
      seg      <= w_seg;
      an       <= w_an;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_panel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_io_panel : self-checking bench for io_panel (SCAN_DIV=4, DEBOUNCE=8)    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_io_panel;

  localparam int S     = 4;
  localparam int DEB   = 8;
  localparam int FRAME = 4 * S;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic [15:0] sw      = 16'h0;
  logic [15:0] cpu_out = 16'h0;
  logic [15:0] cpu_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame;

  io_panel #(
    .DATA_WIDTH      (16),
    .SCAN_DIV        (S),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .cpu_out (cpu_out),
    .cpu_in  (cpu_in),
    .seg     (seg),
    .an      (an),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: edges since release, cpu_out seen at each edge, sw samples
  int          mt;
  logic [15:0] hist [0:4095];
  logic [15:0] swq [$];
  logic [15:0] m_cpu_in;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0][6:0] segs;
  } vec_t;
  vec_t vecs [7];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mt       = 0;
    m_cpu_in = 16'h0;
    swq.delete();
    repeat (DEB + 3) swq.push_back(16'h0);
  endtask

  // One clock: sample inputs, advance model on the edge, compare at the falling edge
  task automatic step();
    logic [15:0] s_out, s_sw, disp;
    logic [3:0]  e_an;
    logic        ok, e_frame;
    int          slot, f;
    s_out = cpu_out;
    s_sw  = sw;
    @(posedge clk);
    mt++;
    if (mt < 4096) hist[mt] = s_out;
    swq.push_back(s_sw);
    if (swq.size() > DEB + 3) void'(swq.pop_front());
    ok = 1'b1;
    for (int i = 0; i <= DEB; i++) if (swq[i] !== swq[DEB]) ok = 1'b0;
    if (ok) m_cpu_in = swq[DEB];
    slot    = ((mt - 1) / S) % 4;
    f       = (mt - 1) / FRAME;
    disp    = (f == 0) ? 16'h0 : hist[(FRAME * f) % 4096];
    e_an    = 4'b0001 << slot;
    e_an    = ~e_an;
    e_frame = (f >= 1) && (((mt - 1) % FRAME) == 0);
    @(negedge clk);
    chk("model_cpu_in", cpu_in, m_cpu_in);
    chk("model_an", {12'h0, an}, {12'h0, e_an});
    chk("model_seg", {9'h0, seg}, {9'h0, hex7(disp[slot*4 +: 4])});
    chk("model_frame", {15'h0, frame}, {15'h0, e_frame});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_in"}, cpu_in, 16'h0);
    chk({tag, "_an"}, {12'h0, an}, 16'h000F);
    chk({tag, "_seg"}, {9'h0, seg}, 16'h007F);
    chk({tag, "_frame"}, {15'h0, frame}, 16'h0);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_immediate");
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst_held");
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame !== 1'b1 && n < FRAME + 2);
    chk("frame_seen", {15'h0, frame}, 16'h1);
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int hold;
    logic [3:0] e_an;

    vecs[0] = '{16'h1A2F, {7'h79, 7'h08, 7'h24, 7'h0E}};
    vecs[1] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[2] = '{16'hBEEF, {7'h03, 7'h06, 7'h06, 7'h0E}};
    vecs[3] = '{16'h0000, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[4] = '{16'hC0DE, {7'h46, 7'h40, 7'h21, 7'h06}};
    vecs[5] = '{16'h5678, {7'h12, 7'h02, 7'h78, 7'h00}};
    vecs[6] = '{16'h9D43, {7'h10, 7'h21, 7'h19, 7'h30}};

    cpu_out = vecs[0].value;
    #2;
    do_reset(3);

    // Table: each value shown for a full frame; next value driven during D2 must not tear
    for (int i = 0; i < 7; i++) begin
      wait_frame();
      if (i == 0) chk("first_frame_cycle", 16'(mt), 16'd17);
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < S; c++) begin
          if (!(d == 0 && c == 0)) step();
          if (d == 2 && c == 1 && i < 6) cpu_out = vecs[i+1].value;
          e_an = 4'b0001 << d;
          e_an = ~e_an;
          chk("vec_seg", {9'h0, seg}, {9'h0, vecs[i].segs[d]});
          chk("vec_an", {12'h0, an}, {12'h0, e_an});
        end
      end
    end

    // Asynchronous reset in D2 after BEEF is showing
    cpu_out = 16'hBEEF;
    wait_frame();
    wait_frame();
    repeat (2 * S) step();
    chk("pre_reset_an", {12'h0, an}, 16'h000B);
    chk("pre_reset_seg", {9'h0, seg}, 16'h0006);
    cpu_out = 16'h1234;
    do_reset(1);
    for (int k = 0; k < FRAME; k++) begin
      step();
      chk("post_reset_zero", {9'h0, seg}, 16'h0040);
    end
    wait_frame();
    chk("post_reset_latch", {9'h0, seg}, 16'h0019);

    // Debounce accept: exactly DEB+3 edges
    sw = 16'h0009;
    for (int k = 1; k <= DEB + 3; k++) begin
      step();
      if (k == DEB + 2) chk("deb_not_early", cpu_in, 16'h0);
    end
    chk("deb_accept", cpu_in, 16'h0009);

    // Debounce reject: short pulses never reach the window
    sw = 16'h0;
    repeat (DEB + 4) step();
    chk("deb_back_zero", cpu_in, 16'h0);
    for (int r = 0; r < 4; r++) begin
      sw = 16'h0009;
      repeat (5) begin step(); chk("deb_reject", cpu_in, 16'h0); end
      sw = 16'h0;
      repeat (5) begin step(); chk("deb_reject", cpu_in, 16'h0); end
    end
    sw = 16'h0009;
    for (int k = 1; k <= DEB + 3; k++) begin
      step();
      if (k == DEB + 2) chk("deb2_not_early", cpu_in, 16'h0);
    end
    chk("deb2_accept", cpu_in, 16'h0009);

    // Randomized traffic against the model, with one reset in the middle
    hold = 0;
    for (int k = 0; k < 900; k++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 14);
        sw   = ($urandom_range(0, 2) == 0) ? 16'($urandom) : (sw ^ 16'h0009);
      end
      hold--;
      if ($urandom_range(0, 4) == 0) cpu_out = 16'($urandom);
      if (k == 450) do_reset($urandom_range(1, 3));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
